rsa_encrypt: RTL
================

# rsa_encrypt

Sequential RSA encryptor computing c = m^e mod n by right-to-left square-and-multiply over bit-serial interleaved modular multiplications. It is the transmit-side counterpart to privatekeyGen: it encrypts with the public pair (e, n), and the matching decryptor uses the d produced by privatekeyGen. Operands are 12-bit, matching the key-generation datapath. Fixed, data-independent latency.

## Interface
- WIDTH, 12, operand width of m, e, n and c.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- m  in  WIDTH  plaintext; captured on the accepting edge.
- e  in  WIDTH  public exponent; captured on the accepting edge.
- n  in  WIDTH  modulus; captured on the accepting edge.
- c  out  WIDTH  ciphertext; held until the next accepted start.
- busy  out  1  high while computing.
- flag  out  1  one-cycle completion pulse.
- err  out  1  operand error; valid with flag, held with c.

## Operation
- States: IDLE, MUL_R, MUL_B, DONE.
- IDLE: start=1 captures m, e, n into internal registers. Later input changes have no effect.
- Error check at acceptance: n < 2 or m >= n -> DONE directly, c=0, err=1.
- Otherwise: base=m, result=1, ebits=e, bit index=0, err=0, enter MUL_R.
- Modular multiply P = a*b mod n, WIDTH steps, MSB of a first:
  - P starts at 0.
  - Each step: P = 2P; if P >= n then P -= n.
  - Then if a[i]: P += b; if P >= n then P -= n.
  - Intermediates are WIDTH+1 bits. Operands are always < n.
- MUL_R: a=result, b=base. Runs all WIDTH steps regardless of ebits[0]. On the final step, result is updated only if ebits[0]=1.
- MUL_B: a=base, b=base. On the final step, base <= P, ebits >>= 1 and the bit index increments.
  - Index reaches WIDTH -> DONE.
  - Otherwise -> MUL_R.
- DONE: c <= result (or 0 on error), flag=1 for one cycle, then -> IDLE.
- e=0 gives c=1. m=0 gives c=0 (for e>0).
- start while not in IDLE is ignored, not queued.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE, c=0, busy=0, flag=0, err=0, internal registers cleared.
- Reset mid-operation aborts the computation. No flag is produced for the aborted request.
- Edge 0 is the edge accepting start.
- busy is 1 from edge 0 until the edge on which flag rises, then 0.
- Normal path:
  - Compute occupies 2*WIDTH*WIDTH = 288 cycles (edges 1..288).
  - flag and the new c appear after edge 289 and are high for exactly one cycle.
  - Total latency is 289 clocks.
- Error path: flag, err=1 and c=0 appear after edge 1. Latency is 1 clock.
- start held high continuously: the next request is accepted on the first edge in IDLE after flag drops. flag pulses are separated by 290 clocks.
- c and err change only on the flag cycle or on reset.

## Test plan
- Reset, then m=9, e=7, n=143, start for 1 cycle -> busy for 289 cycles; flag pulse with c=48, err=0.
- Back-to-back at n=143, e=7:
  - m=2 -> c=128.
  - m=142 -> c=142.
  - m=0 -> c=0.
  - Each result has latency exactly 289 clocks.
- m=9, e=0, n=143 -> c=1. m=1, e=4095, n=4095 -> c=1. Latency is still 289 for both.
- Error cases:
  - m=143, n=143 -> flag after 1 clock, err=1, c=0.
  - n=1 -> err=1.
  - The following valid request clears err.
- Pulse start mid-computation, and change m/e/n after acceptance -> no effect on the result; c=48 for the original m=9, e=7, n=143.
- Assert rst_n=0 at cycle 100 of a computation -> all outputs 0 the next cycle, no flag. A fresh request afterwards completes correctly.

Source files
------------

// File: rtl/rsa_encrypt.sv
// rsa_encrypt: computes c = m^e mod n using right-to-left square-and-multiply.
// Each modular product is formed bit-serially (interleaved shift/add/reduce),
// one multiplier bit per clock. The latency does not depend on the data:
// every exponent bit costs one MUL_R pass and one MUL_B pass of WIDTH steps.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// MUL_R | P = result * base mod n; result takes P only when ebits[0] = 1
// MUL_B | P = base * base mod n; base takes P, the exponent shifts right
// DONE  | publishes c/err and pulses flag for one cycle
module rsa_encrypt #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             flag,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_R = 2'd1,
    MUL_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] ebits_q, ebits_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    step_q, step_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             err_pend_q, err_pend_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             err_q, err_d;
  logic             flag_q, flag_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_op;
  logic [CW-1:0]    bit_sel;
  logic             a_bit;
  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   red1;
  logic [WIDTH:0]   add;
  logic [WIDTH:0]   red2;
  logic [WIDTH-1:0] p_next;
  logic             last_step;
  logic             last_bit;
  logic             op_err;

  // One interleaved multiply step: double, reduce, conditionally add base, reduce.
  // Both operands stay below n, so every intermediate fits in WIDTH+1 bits.
  always_comb begin
    a_op      = (state_q == MUL_B) ? base_q : result_q;
    bit_sel   = CW'(WIDTH - 1) - step_q;
    a_bit     = a_op[bit_sel];
    n_ext     = {1'b0, n_q};
    dbl       = {p_q, 1'b0};
    red1      = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    add       = a_bit ? (red1 + {1'b0, base_q}) : red1;
    red2      = (add >= n_ext) ? (add - n_ext) : add;
    p_next    = WIDTH'(red2);
    last_step = (step_q == CW'(WIDTH - 1));
    last_bit  = (idx_q == CW'(WIDTH - 1));
    op_err    = (n < WIDTH'(2)) || (m >= n);
  end

  // Next-state and register updates for the sequencer and datapath.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    base_d     = base_q;
    result_d   = result_q;
    ebits_d    = ebits_q;
    p_d        = p_q;
    step_d     = step_q;
    idx_d      = idx_q;
    err_pend_d = err_pend_q;
    c_d        = c_q;
    err_d      = err_q;
    flag_d     = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = n;
          base_d   = m;
          ebits_d  = e;
          result_d = WIDTH'(1);
          p_d      = '0;
          step_d   = '0;
          idx_d    = '0;
          busy_d   = 1'b1;
          if (op_err) begin
            err_pend_d = 1'b1;
            state_d    = DONE;
          end else begin
            err_pend_d = 1'b0;
            state_d    = MUL_R;
          end
        end
      end

      MUL_R: begin
        p_d    = p_next;
        step_d = step_q + CW'(1);
        if (last_step) begin
          // The multiply always runs its full length; only the write-back is gated.
          if (ebits_q[0]) begin
            result_d = p_next;
          end
          p_d     = '0;
          step_d  = '0;
          state_d = MUL_B;
        end
      end

      MUL_B: begin
        p_d    = p_next;
        step_d = step_q + CW'(1);
        if (last_step) begin
          base_d  = p_next;
          ebits_d = ebits_q >> 1;
          idx_d   = idx_q + CW'(1);
          p_d     = '0;
          step_d  = '0;
          state_d = last_bit ? DONE : MUL_R;
        end
      end

      DONE: begin
        c_d     = err_pend_q ? '0 : result_q;
        err_d   = err_pend_q;
        flag_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      base_q     <= '0;
      result_q   <= '0;
      ebits_q    <= '0;
      p_q        <= '0;
      step_q     <= '0;
      idx_q      <= '0;
      err_pend_q <= 1'b0;
      c_q        <= '0;
      err_q      <= 1'b0;
      flag_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      base_q     <= base_d;
      result_q   <= result_d;
      ebits_q    <= ebits_d;
      p_q        <= p_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      err_pend_q <= err_pend_d;
      c_q        <= c_d;
      err_q      <= err_d;
      flag_q     <= flag_d;
      busy_q     <= busy_d;
    end
  end

  assign c    = c_q;
  assign err  = err_q;
  assign flag = flag_q;
  assign busy = busy_q;

endmodule
